// File: rtl/sm_mac_pipe_if.sv
// Operand/result handshake bundle for the sign-magnitude MAC pipeline.
// The slave side is the MAC; the master side feeds operands and drains results.
interface sm_mac_pipe_if #(
  parameter int DW = 10,
  parameter int AW = 24
);
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          out_ovf;

  modport slave (
    input  clr, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

  modport master (
    output clr, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/sm_mac_pipe.sv
// Sign-magnitude multiply-accumulate: input register, product stage, accumulate stage.
// Every TAPS products yield one saturated result held until the consumer takes it.
module sm_mac_pipe #(
  parameter int DW   = 10,
  parameter int AW   = 24,
  parameter int TAPS = 16
) (
  input  logic         clk,
  input  logic         rst,
  sm_mac_pipe_if.slave bus
);
  localparam int MW = DW - 1;
  localparam int PW = 2 * MW;
  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [AW-2:0] MAG_MAX  = '1;
  localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

  logic          stall;
  logic          accept;
  logic          s0_valid;
  logic [DW-1:0] s0_a;
  logic [DW-1:0] s0_b;
  logic          s1_valid;
  logic          s1_sign;
  logic [PW-1:0] s1_mag;
  logic          acc_sign;
  logic          acc_ovf;
  logic [AW-2:0] acc_mag;
  logic [CW-1:0] tap_cnt;
  logic [PW-1:0] prod_mag;
  logic          prod_sign;
  logic [AW-1:0] a_ext;
  logic [AW-1:0] p_ext;
  logic [AW-1:0] sum_raw;
  logic          sum_sign;
  logic          res_sign;
  logic          res_ovf;
  logic [AW-2:0] res_mag;
  logic          last_tap;
  logic          load;
  logic          out_valid_q;
  logic          out_ovf_q;
  logic [AW-1:0] out_data_q;

  assign stall        = out_valid_q && !bus.out_ready;
  assign bus.in_ready = !stall;
  assign accept       = bus.in_valid && !stall && !bus.clr;

  assign prod_mag  = PW'(s0_a[MW-1:0]) * PW'(s0_b[MW-1:0]);
  assign prod_sign = (s0_a[DW-1] ^ s0_b[DW-1]) && (prod_mag != '0);

  assign a_ext = {1'b0, acc_mag};
  assign p_ext = AW'(s1_mag);

  // One spare top bit in sum_raw flags a magnitude beyond the representable range.
  always_comb begin
    sum_raw  = '0;
    sum_sign = 1'b0;
    if (acc_sign == s1_sign) begin
      sum_raw  = a_ext + p_ext;
      sum_sign = acc_sign;
    end else if (a_ext >= p_ext) begin
      sum_raw  = a_ext - p_ext;
      sum_sign = acc_sign;
    end else begin
      sum_raw  = p_ext - a_ext;
      sum_sign = s1_sign;
    end
    res_sign = sum_sign && (sum_raw != '0);
    res_mag  = sum_raw[AW-1] ? MAG_MAX : sum_raw[AW-2:0];
    res_ovf  = acc_ovf || sum_raw[AW-1];
  end

  assign last_tap = (tap_cnt == LAST_TAP);
  assign load     = !bus.clr && !stall && s1_valid && last_tap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      acc_sign <= 1'b0;
      acc_mag  <= '0;
      acc_ovf  <= 1'b0;
      tap_cnt  <= '0;
    end else if (bus.clr) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      acc_sign <= 1'b0;
      acc_mag  <= '0;
      acc_ovf  <= 1'b0;
      tap_cnt  <= '0;
    end else if (!stall) begin
      s0_valid <= accept;
      if (accept) begin
        s0_a <= bus.in_a;
        s0_b <= bus.in_b;
      end
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_sign <= prod_sign;
        s1_mag  <= prod_mag;
      end
      if (s1_valid) begin
        if (last_tap) begin
          acc_sign <= 1'b0;
          acc_mag  <= '0;
          acc_ovf  <= 1'b0;
          tap_cnt  <= '0;
        end else begin
          acc_sign <= res_sign;
          acc_mag  <= res_mag;
          acc_ovf  <= res_ovf;
          tap_cnt  <= tap_cnt + CW'(1);
        end
      end
    end
  end

  // The result handshake completes even during a frame abort; abort never touches the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= {res_sign, res_mag};
      out_ovf_q   <= res_ovf;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_sm_mac_pipe.sv
// Four MAC configurations share one directed stimulus stream; an integer-arithmetic
// frame model predicts every output, and literal expectations pin the key scenarios.
module tb_sm_mac_pipe;
  logic       clk;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic       out_ready;
  logic [9:0] in_a;
  logic [9:0] in_b;

  int n_chk  = 0;
  int n_pass = 0;

  sm_mac_pipe_if #(.DW(10), .AW(24)) if4 ();
  sm_mac_pipe_if #(.DW(10), .AW(24)) if2 ();
  sm_mac_pipe_if #(.DW(10), .AW(24)) if1 ();
  sm_mac_pipe_if #(.DW(10), .AW(19)) ifs ();

  sm_mac_pipe #(.DW(10), .AW(24), .TAPS(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
  sm_mac_pipe #(.DW(10), .AW(24), .TAPS(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  sm_mac_pipe #(.DW(10), .AW(24), .TAPS(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  sm_mac_pipe #(.DW(10), .AW(19), .TAPS(2)) us (.clk(clk), .rst(rst), .bus(ifs.slave));

  assign if4.clr = clr;  assign if4.in_valid = in_valid;  assign if4.in_a = in_a;
  assign if4.in_b = in_b;  assign if4.out_ready = out_ready;
  assign if2.clr = clr;  assign if2.in_valid = in_valid;  assign if2.in_a = in_a;
  assign if2.in_b = in_b;  assign if2.out_ready = out_ready;
  assign if1.clr = clr;  assign if1.in_valid = in_valid;  assign if1.in_a = in_a;
  assign if1.in_b = in_b;  assign if1.out_ready = out_ready;
  assign ifs.clr = clr;  assign ifs.in_valid = in_valid;  assign ifs.in_a = in_a;
  assign ifs.in_b = in_b;  assign ifs.out_ready = out_ready;

  logic        dv[4];
  logic        dr[4];
  logic        dov[4];
  logic [23:0] dd[4];
  assign dv[0] = if4.out_valid;  assign dr[0] = if4.in_ready;  assign dov[0] = if4.out_ovf;
  assign dv[1] = if2.out_valid;  assign dr[1] = if2.in_ready;  assign dov[1] = if2.out_ovf;
  assign dv[2] = if1.out_valid;  assign dr[2] = if1.in_ready;  assign dov[2] = if1.out_ovf;
  assign dv[3] = ifs.out_valid;  assign dr[3] = ifs.in_ready;  assign dov[3] = ifs.out_ovf;
  assign dd[0] = if4.out_data;
  assign dd[1] = if2.out_data;
  assign dd[2] = if1.out_data;
  assign dd[3] = {5'b0, ifs.out_data};

  int taps_m[4] = '{4, 2, 1, 2};
  int aw_m[4]   = '{24, 24, 24, 19};

  // Model: products travel through a two-slot latency line, then join the frame sum.
  bit     m_v0[4];
  bit     m_v1[4];
  longint m_p0[4];
  longint m_p1[4];
  longint m_sum[4];
  bit     m_ovf[4];
  int     m_cnt[4];
  bit     e_valid[4];
  longint e_val[4];
  bit     e_ovf[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint sm2int(logic [9:0] x);
    return x[9] ? -longint'(x[8:0]) : longint'(x[8:0]);
  endfunction

  function automatic logic [23:0] enc(longint v, int aw);
    logic [23:0] r;
    longint      m;
    m = (v < 0) ? -v : v;
    r = 24'(m);
    if (v < 0) r[aw-1] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  initial begin
    bit     stl, cons, ld;
    longint s, mx;
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 4; i++) begin
        if (rst) begin
          m_v0[i] = 0; m_v1[i] = 0; m_sum[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
          e_valid[i] = 0; e_val[i] = 0; e_ovf[i] = 0;
        end else begin
          stl  = e_valid[i] && !out_ready;
          cons = e_valid[i] && out_ready;
          ld   = 0;
          if (clr) begin
            m_v0[i] = 0; m_v1[i] = 0; m_sum[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
          end else if (!stl) begin
            if (m_v1[i]) begin
              mx = (longint'(1) << (aw_m[i] - 1)) - 1;
              s  = m_sum[i] + m_p1[i];
              if (s > mx)  begin s = mx;  m_ovf[i] = 1; end
              if (s < -mx) begin s = -mx; m_ovf[i] = 1; end
              m_cnt[i]++;
              if (m_cnt[i] == taps_m[i]) begin
                ld = 1; e_val[i] = s; e_ovf[i] = m_ovf[i];
                m_sum[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
              end else begin
                m_sum[i] = s;
              end
            end
            m_v1[i] = m_v0[i];
            m_p1[i] = m_p0[i];
            m_v0[i] = in_valid;
            m_p0[i] = sm2int(in_a) * sm2int(in_b);
          end
          if (ld) e_valid[i] = 1;
          else if (cons) e_valid[i] = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("u%0d in_ready", i), 32'(dr[i]), 32'(!(e_valid[i] && !out_ready)));
          chk($sformatf("u%0d out_valid", i), 32'(dv[i]), 32'(e_valid[i]));
          if (e_valid[i]) begin
            chk($sformatf("u%0d out_data", i), 32'(dd[i]), 32'(enc(e_val[i], aw_m[i])));
            chk($sformatf("u%0d out_ovf", i), 32'(dov[i]), 32'(e_ovf[i]));
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input logic [9:0] a, input logic [9:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst u%0d out_valid", i), 32'(dv[i]), 32'd0);
      chk($sformatf("rst u%0d out_data", i), 32'(dd[i]), 32'd0);
      chk($sformatf("rst u%0d out_ovf", i), 32'(dov[i]), 32'd0);
      chk($sformatf("rst u%0d in_ready", i), 32'(dr[i]), 32'd1);
    end
    rst = 1'b0;
  endtask

  task automatic wait_v(input int i, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dv[i] && n < maxc);
    if (!dv[i]) begin
      n_chk++;
      $display("FAIL timeout u%0d: out_valid low after %0d cycles, want high", i, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc();

    // Mixed signs: 15 - 14 - 1 + 100 = +100
    do_reset();
    cyc();
    pair(10'd3, 10'd5);
    pair(10'h202, 10'd7);
    pair(10'd1, 10'h201);
    pair(10'd10, 10'd10);
    wait_v(0, 8, n);
    chk("mixed latency", 32'(n), 32'd3);
    chk("mixed data", 32'(dd[0]), 32'h000064);
    chk("mixed ovf", 32'(dov[0]), 32'd0);
    @(negedge clk);
    chk("mixed one cycle", 32'(dv[0]), 32'd0);
    repeat (3) cyc();

    // Cancellation to +0, and -0 times +7
    do_reset();
    cyc();
    pair(10'd4, 10'd4);
    pair(10'h204, 10'd4);
    wait_v(1, 8, n);
    chk("cancel latency", 32'(n), 32'd3);
    chk("cancel data", 32'(dd[1]), 32'h000000);
    repeat (3) cyc();
    do_reset();
    cyc();
    pair(10'h200, 10'd7);
    wait_v(2, 8, n);
    chk("neg zero latency", 32'(n), 32'd3);
    chk("neg zero data", 32'(dd[2]), 32'h000000);
    repeat (3) cyc();

    // Saturation on the 19-bit instance, then a clean frame
    do_reset();
    cyc();
    pair(10'h3FF, 10'h1FF);
    pair(10'h3FF, 10'h1FF);
    wait_v(3, 8, n);
    chk("sat data", 32'(dd[3]), 32'h07FFFF);
    chk("sat ovf", 32'(dov[3]), 32'd1);
    pair(10'd1, 10'd1);
    pair(10'd1, 10'd1);
    wait_v(3, 8, n);
    chk("post sat data", 32'(dd[3]), 32'h000002);
    chk("post sat ovf", 32'(dov[3]), 32'd0);
    repeat (3) cyc();

    // Backpressure: +6 held, inputs keep arriving, then released
    do_reset();
    cyc();
    out_ready = 1'b0;
    pair(10'd1, 10'd3);
    pair(10'd1, 10'd3);
    in_valid = 1'b1; in_a = 10'd2; in_b = 10'd2;
    wait_v(1, 8, n);
    chk("bp latency", 32'(n), 32'd3);
    chk("bp data", 32'(dd[1]), 32'h000006);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp hold valid", 32'(dv[1]), 32'd1);
      chk("bp hold data", 32'(dd[1]), 32'h000006);
      chk("bp in_ready", 32'(dr[1]), 32'd0);
    end
    cyc();
    out_ready = 1'b1;
    cyc();
    wait_v(1, 10, n);
    chk("bp next data", 32'(dd[1]), 32'h000008);
    in_valid = 1'b0;
    repeat (4) cyc();

    // Abort mid-frame with a pair presented during clr
    do_reset();
    cyc();
    pair(10'd5, 10'd5);
    pair(10'd5, 10'd5);
    clr = 1'b1;
    pair(10'd7, 10'd7);
    clr = 1'b0;
    for (int p = 0; p < 4; p++) pair(10'd1, 10'd1);
    wait_v(0, 8, n);
    chk("abort latency", 32'(n), 32'd3);
    chk("abort data", 32'(dd[0]), 32'h000004);
    chk("abort ovf", 32'(dov[0]), 32'd0);
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
